// File: rtl/ct_spsram_2048x88_ctrl_pkg.sv
// Shared constants for the 2048x88 single-port SRAM access controller.
package ct_spsram_ctrl_pkg;
  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 88;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic RR_WR = 1'b0;
  localparam logic RR_RD = 1'b1;
endpackage

// File: rtl/ct_spsram_2048x88_ctrl_if.sv
// Requester-side bus: write/read request channels, flush and init status.
interface ct_spsram_2048x88_ctrl_if
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  flush_req;
  logic                  init_busy;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_gnt;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output flush_req, wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr,
    input  init_busy, wr_gnt, rd_gnt, rd_vld, rd_data
  );

  modport slave (
    input  flush_req, wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr,
    output init_busy, wr_gnt, rd_gnt, rd_vld, rd_data
  );
endinterface

// File: rtl/ct_spsram_2048x88_ctrl_arb.sv
// Two-requester round-robin arbiter; the pointer only moves on contention.
module ct_spsram_rr_arb
  import ct_spsram_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt
);
  logic rr;

  assign wr_gnt = en & wr_req & (~rd_req | (rr == RR_WR));
  assign rd_gnt = en & rd_req & (~wr_req | (rr == RR_RD));

  always_ff @(posedge clk) begin
    if (rst)                           rr <= RR_WR;
    else if (en && wr_req && rd_req)   rr <= ~rr;
  end
endmodule

// File: rtl/ct_spsram_2048x88_ctrl.sv
// Single-port SRAM controller: init sweep, round-robin wr/rd sharing, registered read data.
module ct_spsram_2048x88_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  ct_spsram_2048x88_ctrl_if.slave bus,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  localparam int STAGES = 1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [STAGES:0]       vld_pipe;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  run;
  logic                  wr_gnt;
  logic                  rd_gnt;

  assign run = (state == ST_RUN);

  ct_spsram_rr_arb u_arb (
    .clk    (forever_cpuclk),
    .rst    (cpurst),
    .en     (run),
    .wr_req (bus.wr_req),
    .rd_req (bus.rd_req),
    .wr_gnt (wr_gnt),
    .rd_gnt (rd_gnt)
  );

  // Sweep counter wraps naturally to 0 on the final entry.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) state <= ST_RUN;
    end else if (bus.flush_req) begin
      state <= ST_INIT;
      cnt   <= '0;
    end
  end

  // Grant in N -> Q valid in N+1 -> rd_vld in N+2; keeps running across a flush.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      vld_pipe  <= '0;
      rd_data_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_gnt};
      if (vld_pipe[0]) rd_data_q <= sram_q;
    end
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt;
      sram_d    = INIT_VAL;
    end else if (wr_gnt) begin
      // An all-zero mask is still granted but makes no array access.
      sram_cen  = ~|bus.wr_mask;
      sram_gwen = 1'b0;
      sram_wen  = ~bus.wr_mask;
      sram_a    = bus.wr_addr;
      sram_d    = bus.wr_data;
    end else if (rd_gnt) begin
      sram_cen  = 1'b0;
      sram_a    = bus.rd_addr;
    end
  end

  assign bus.init_busy = (state == ST_INIT);
  assign bus.wr_gnt    = wr_gnt;
  assign bus.rd_gnt    = rd_gnt;
  assign bus.rd_vld    = vld_pipe[STAGES];
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_ct_spsram_2048x88_ctrl.sv
// Directed bench for the SRAM controller with a behavioural 2048x88 macro model.
module tb_ct_spsram_2048x88_ctrl;
  localparam int AW = 11;
  localparam int DW = 88;

  logic          clk;
  logic          cpurst;
  logic [AW-1:0] sram_a;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vecs = 0;
  int errs = 0;

  logic [DW-1:0] pat_a5, pat_3c, pat_66, pat_part;

  ct_spsram_2048x88_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_spsram_2048x88_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VAL('0)) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .bus            (bus),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sram_q = '0;
  end

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] ai;
    cpurst = 1'b1;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    vecs++; if ({bus.init_busy, bus.rd_vld, bus.wr_gnt, bus.rd_gnt} !== 4'b1000) begin
      errs++; $display("FAIL reset_flags: got %b want 1000", {bus.init_busy, bus.rd_vld, bus.wr_gnt, bus.rd_gnt}); end
    vecs++; if (bus.rd_data !== '0) begin
      errs++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    bus.wr_req = 1'b0;
    tick();
    cpurst = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      ai = i[AW-1:0];
      @(negedge clk);
      vecs++; if (sram_a !== ai) begin
        errs++; $display("FAIL sweep_addr: got %0d want %0d", sram_a, ai); end
      vecs++; if ({bus.init_busy, sram_cen, sram_gwen, bus.rd_gnt, bus.wr_gnt} !== 5'b10000) begin
        errs++; $display("FAIL sweep_ctl at %0d: got %b want 10000", i,
                         {bus.init_busy, sram_cen, sram_gwen, bus.rd_gnt, bus.wr_gnt}); end
      vecs++; if ((sram_wen | sram_d) !== '0) begin
        errs++; $display("FAIL sweep_wen_d at %0d: got wen %h d %h want 0", i, sram_wen, sram_d); end
      tick();
    end
    @(negedge clk);
    vecs++; if ({bus.init_busy, bus.rd_gnt} !== 2'b01) begin
      errs++; $display("FAIL sweep_end: got busy/rd_gnt %b want 01", {bus.init_busy, bus.rd_gnt}); end
    tick();
    bus.rd_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_write_read();
    bus.wr_req = 1'b1; bus.wr_addr = 11'h5A5; bus.wr_data = pat_a5; bus.wr_mask = '1;
    @(negedge clk);
    vecs++; if ({bus.wr_gnt, sram_cen, sram_gwen} !== 3'b100) begin
      errs++; $display("FAIL wr_ctl: got %b want 100", {bus.wr_gnt, sram_cen, sram_gwen}); end
    vecs++; if (sram_a !== 11'h5A5 || sram_d !== pat_a5 || sram_wen !== '0) begin
      errs++; $display("FAIL wr_bus: got a %h d %h wen %h", sram_a, sram_d, sram_wen); end
    tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 11'h5A5;
    @(negedge clk);
    vecs++; if ({bus.rd_gnt, sram_cen, sram_gwen} !== 3'b101 || sram_a !== 11'h5A5) begin
      errs++; $display("FAIL rd_ctl: got %b a %h want 101 a 5a5", {bus.rd_gnt, sram_cen, sram_gwen}, sram_a); end
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    vecs++; if (bus.rd_vld !== 1'b0) begin
      errs++; $display("FAIL rd_vld_early: got %b want 0", bus.rd_vld); end
    tick();
    @(negedge clk);
    vecs++; if (bus.rd_vld !== 1'b1 || bus.rd_data !== pat_a5) begin
      errs++; $display("FAIL rd_data: got vld %b data %h want 1 %h", bus.rd_vld, bus.rd_data, pat_a5); end
    tick();
    @(negedge clk);
    vecs++; if (bus.rd_vld !== 1'b0 || bus.rd_data !== pat_a5) begin
      errs++; $display("FAIL rd_hold: got vld %b data %h want 0 %h", bus.rd_vld, bus.rd_data, pat_a5); end
    tick();
  endtask

  task automatic test_partial_write();
    bus.wr_req = 1'b1; bus.wr_addr = 11'h7FF; bus.wr_data = '1; bus.wr_mask = '1;
    tick();
    bus.wr_data = '0; bus.wr_mask = 88'hFF;
    @(negedge clk);
    vecs++; if (sram_wen !== {{80{1'b1}}, 8'h00} || sram_cen !== 1'b0) begin
      errs++; $display("FAIL part_wen: got %h cen %b", sram_wen, sram_cen); end
    tick();
    bus.wr_mask = '0;
    @(negedge clk);
    vecs++; if ({bus.wr_gnt, sram_cen} !== 2'b11) begin
      errs++; $display("FAIL zero_mask: got gnt/cen %b want 11", {bus.wr_gnt, sram_cen}); end
    tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 11'h7FF;
    tick();
    bus.rd_req = 1'b0;
    tick();
    @(negedge clk);
    vecs++; if (bus.rd_vld !== 1'b1 || bus.rd_data !== pat_part) begin
      errs++; $display("FAIL part_read: got vld %b data %h want 1 %h", bus.rd_vld, bus.rd_data, pat_part); end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_w, exp_r, exp_v;
    exp_w = 6'b000101; exp_r = 6'b001010; exp_v = 6'b101000;
    bus.wr_addr = 11'h123; bus.wr_data = pat_3c; bus.wr_mask = '1;
    bus.rd_addr = 11'h5A5;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin bus.wr_req = 1'b0; bus.rd_req = 1'b0; end
      @(negedge clk);
      vecs++; if ({bus.wr_gnt, bus.rd_gnt, bus.rd_vld} !== {exp_w[c], exp_r[c], exp_v[c]}) begin
        errs++; $display("FAIL contend c%0d: got w/r/v %b want %b", c,
                         {bus.wr_gnt, bus.rd_gnt, bus.rd_vld}, {exp_w[c], exp_r[c], exp_v[c]}); end
      if (exp_v[c]) begin
        vecs++; if (bus.rd_data !== pat_a5) begin
          errs++; $display("FAIL contend_data c%0d: got %h want %h", c, bus.rd_data, pat_a5); end
      end
      tick();
    end
    bus.rd_req = 1'b1; bus.rd_addr = 11'h123;
    tick();
    bus.rd_req = 1'b0;
    tick();
    @(negedge clk);
    vecs++; if (bus.rd_vld !== 1'b1 || bus.rd_data !== pat_3c) begin
      errs++; $display("FAIL contend_wr_landed: got vld %b data %h want 1 %h", bus.rd_vld, bus.rd_data, pat_3c); end
    repeat (2) tick();
  endtask

  task automatic test_flush();
    int busy;
    bus.wr_req = 1'b1; bus.wr_addr = 11'd100; bus.wr_data = pat_66; bus.wr_mask = '1;
    tick();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 11'h5A5; bus.flush_req = 1'b1;
    @(negedge clk);
    vecs++; if ({bus.rd_gnt, bus.init_busy} !== 2'b10) begin
      errs++; $display("FAIL flush_gnt: got gnt/busy %b want 10", {bus.rd_gnt, bus.init_busy}); end
    tick();
    bus.rd_req = 1'b0; bus.flush_req = 1'b0;
    @(negedge clk);
    vecs++; if ({bus.init_busy, bus.rd_vld} !== 2'b10 || sram_a !== '0) begin
      errs++; $display("FAIL flush_enter: got busy/vld %b a %0d want 10 a 0", {bus.init_busy, bus.rd_vld}, sram_a); end
    tick();
    @(negedge clk);
    vecs++; if (bus.rd_vld !== 1'b1 || bus.rd_data !== pat_a5) begin
      errs++; $display("FAIL flush_inflight: got vld %b data %h want 1 %h", bus.rd_vld, bus.rd_data, pat_a5); end
    busy = 2;
    for (int k = 0; k < 3000; k++) begin
      tick();
      bus.flush_req = (k == 10);
      @(negedge clk);
      if (!bus.init_busy) break;
      busy++;
    end
    bus.flush_req = 1'b0;
    vecs++; if (busy !== 2048) begin
      errs++; $display("FAIL flush_sweep_len: got %0d want 2048", busy); end
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 11'd100;
    tick();
    bus.rd_req = 1'b0;
    tick();
    @(negedge clk);
    vecs++; if (bus.rd_vld !== 1'b1 || bus.rd_data !== '0) begin
      errs++; $display("FAIL flush_init_val: got vld %b data %h want 1 0", bus.rd_vld, bus.rd_data); end
    repeat (2) tick();
  endtask

  task automatic test_mid_reset();
    int  busy;
    bit  found;
    bus.rd_req = 1'b1; bus.rd_addr = 11'h5A5;
    @(negedge clk);
    vecs++; if (bus.rd_gnt !== 1'b1) begin
      errs++; $display("FAIL mr_rd_gnt: got %b want 1", bus.rd_gnt); end
    tick();
    bus.rd_req = 1'b0; cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    @(negedge clk);
    vecs++; if ({bus.rd_vld, bus.init_busy} !== 2'b01 || sram_a !== '0) begin
      errs++; $display("FAIL mr_drop_vld: got vld/busy %b a %0d want 01 a 0", {bus.rd_vld, bus.init_busy}, sram_a); end
    found = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      tick();
      @(negedge clk);
      if (sram_a == 11'd1000) begin found = 1'b1; break; end
    end
    vecs++; if (found !== 1'b1) begin
      errs++; $display("FAIL mr_reach_1000: got %b want 1", found); end
    tick();
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    @(negedge clk);
    vecs++; if (bus.init_busy !== 1'b1 || sram_a !== '0) begin
      errs++; $display("FAIL mr_restart: got busy %b a %0d want 1 a 0", bus.init_busy, sram_a); end
    busy = 1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      @(negedge clk);
      if (!bus.init_busy) break;
      busy++;
    end
    vecs++; if (busy !== 2048) begin
      errs++; $display("FAIL mr_sweep_len: got %0d want 2048", busy); end
  endtask

  initial begin
    pat_a5   = {11{8'hA5}};
    pat_3c   = {11{8'h3C}};
    pat_66   = {11{8'h66}};
    pat_part = {{10{8'hFF}}, 8'h00};
    cpurst = 1'b1;
    bus.flush_req = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
